// File: rtl/i2s_peak_meter_pkg.sv
// Shared types, defaults and the saturating magnitude helper for the I2S peak meter.
// Consumed by the interface, the per-channel tracker and the top level.
package i2s_meter_pkg;

    localparam int DEF_W_OUT       = 16;
    localparam int DEF_HOLD_FRAMES = 4;
    localparam int DEF_DECAY_SHIFT = 3;

    typedef logic [DEF_W_OUT-1:0] level_t;

    localparam level_t LEVEL_MAX = level_t'({1'b0, {(DEF_W_OUT-1){1'b1}}});
    localparam level_t LEVEL_MIN = level_t'({1'b1, {(DEF_W_OUT-1){1'b0}}});

    typedef struct packed {
        level_t mag;
        logic   clip;
    } abs_t;

    // The most negative sample has no positive twin, so it folds onto full scale.
    function automatic abs_t sat_abs(input level_t sample);
        abs_t                        r;
        logic signed [DEF_W_OUT-1:0] s;
        s = signed'(sample);
        if (sample == LEVEL_MIN) begin
            r.mag = LEVEL_MAX;
        end else if (s < 0) begin
            r.mag = level_t'(-s);
        end else begin
            r.mag = sample;
        end
        r.clip = (r.mag == LEVEL_MAX);
        return r;
    endfunction

endpackage

// File: rtl/i2s_peak_meter_if.sv
// Serial input and level-output bundle of the I2S peak meter.
// master drives the serial line and clip clear; slave is the meter itself.
interface i2s_peak_meter_if;
    import i2s_meter_pkg::*;

    logic       bclk;
    logic       lrclk;
    logic       sd;
    logic       clip_clr;
    level_t     peak_l;
    level_t     peak_r;
    logic       clip_l;
    logic       clip_r;
    logic       valid;
    logic [7:0] bar_l;
    logic [7:0] bar_r;

    modport master (
        output bclk, lrclk, sd, clip_clr,
        input  peak_l, peak_r, clip_l, clip_r, valid, bar_l, bar_r
    );

    modport slave (
        input  bclk, lrclk, sd, clip_clr,
        output peak_l, peak_r, clip_l, clip_r, valid, bar_l, bar_r
    );

endinterface

// File: rtl/i2s_peak_meter_chan.sv
// One channel of the meter: peak capture, hold countdown, exponential decay
// and the sticky clip flag. Updates on the cycle upd_i is high.
module i2s_meter_chan
    import i2s_meter_pkg::*;
#(
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   upd_i,
    input  level_t sample_i,
    input  logic   clip_clr_i,
    output level_t peak_o,
    output logic   clip_o
);
    localparam int                HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

    level_t            peak_q, peak_d, step;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              clip_q, clip_d;
    abs_t              abs_s;

    always_comb begin
        abs_s = sat_abs(sample_i);
        // A minimum step of one keeps small peaks moving so they always reach zero.
        step  = peak_q >> DECAY_SHIFT;
        if (step == '0) begin
            step = level_t'(peak_q != '0);
        end
        peak_d = peak_q;
        hold_d = hold_q;
        clip_d = clip_q & ~clip_clr_i;
        if (upd_i) begin
            if (abs_s.mag > peak_q) begin
                peak_d = abs_s.mag;
                hold_d = HOLD_INIT;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else begin
                peak_d = peak_q - step;
            end
            if (abs_s.clip) begin
                clip_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= '0;
            hold_q <= '0;
            clip_q <= 1'b0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
            clip_q <= clip_d;
        end
    end

    assign peak_o = peak_q;
    assign clip_o = clip_q;

endmodule

// File: rtl/i2s_peak_meter.sv
// I2S stereo deserialiser feeding two peak/hold/decay trackers and clip flags.
// Define I2S_PEAK_METER_BAR_EN to build the registered 8-step thermometer bars.
module i2s_peak_meter
    import i2s_meter_pkg::*;
#(
    parameter int W_SLOT      = 32,
    parameter int W_OUT       = DEF_W_OUT,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
    input logic             clk,
    input logic             rst,
    i2s_peak_meter_if.slave bus
);
    localparam int               CNT_W    = $clog2(W_SLOT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W_SLOT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_SLOT - 1);

    logic              bclk_q, rise;
    logic              lr_prev_q, lr_prev_d, lr_known_q, lr_known_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [W_SLOT-1:0] shreg_q, shreg_d, shifted;
    logic              close_l_q, close_l_d, close_r_q, close_r_d;
    level_t            sample_q, sample_d;
    logic              upd_r_q, valid_q;
    level_t            peak_l, peak_r;
    logic              clip_l, clip_r;

    always_comb begin
        rise       = bus.bclk & ~bclk_q;
        shifted    = {shreg_q[W_SLOT-2:0], bus.sd};
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        lr_prev_d  = lr_prev_q;
        lr_known_d = lr_known_q;
        sample_d   = sample_q;
        close_l_d  = 1'b0;
        close_r_d  = 1'b0;
        if (rise) begin
            if (!lr_known_q) begin
                // Joining mid-stream: park the counter past full so this slot can never close.
                lr_prev_d  = bus.lrclk;
                lr_known_d = 1'b1;
                bit_cnt_d  = CNT_FULL;
            end else if (bus.lrclk != lr_prev_q) begin
                if (bit_cnt_q < CNT_FULL) begin
                    shreg_d = shifted;
                end
                lr_prev_d = bus.lrclk;
                bit_cnt_d = '0;
                if (bit_cnt_q == CNT_LAST) begin
                    sample_d  = shifted[W_SLOT-1 -: W_OUT];
                    close_l_d = ~lr_prev_q;
                    close_r_d = lr_prev_q;
                end
            end else if (bit_cnt_q < CNT_FULL) begin
                shreg_d   = shifted;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_q     <= 1'b0;
            lr_prev_q  <= 1'b0;
            lr_known_q <= 1'b0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            sample_q   <= '0;
            close_l_q  <= 1'b0;
            close_r_q  <= 1'b0;
            upd_r_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            bclk_q     <= bus.bclk;
            lr_prev_q  <= lr_prev_d;
            lr_known_q <= lr_known_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sample_q   <= sample_d;
            close_l_q  <= close_l_d;
            close_r_q  <= close_r_d;
            upd_r_q    <= close_r_q;
            valid_q    <= upd_r_q;
        end
    end

    i2s_meter_chan #(.HOLD_FRAMES(HOLD_FRAMES), .DECAY_SHIFT(DECAY_SHIFT)) u_chan_l (
        .clk        (clk),
        .rst        (rst),
        .upd_i      (close_l_q),
        .sample_i   (sample_q),
        .clip_clr_i (bus.clip_clr),
        .peak_o     (peak_l),
        .clip_o     (clip_l)
    );

    i2s_meter_chan #(.HOLD_FRAMES(HOLD_FRAMES), .DECAY_SHIFT(DECAY_SHIFT)) u_chan_r (
        .clk        (clk),
        .rst        (rst),
        .upd_i      (close_r_q),
        .sample_i   (sample_q),
        .clip_clr_i (bus.clip_clr),
        .peak_o     (peak_r),
        .clip_o     (clip_r)
    );

`ifdef I2S_PEAK_METER_BAR_EN
    logic [7:0] bar_l_q, bar_r_q;

    function automatic logic [7:0] bar_of(input level_t p);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b[k] = (p >= (level_t'(1) << (W_OUT - 8 + k)));
        end
        return b;
    endfunction

    // Bars refresh together with valid, i.e. once per completed frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_l_q <= '0;
            bar_r_q <= '0;
        end else if (upd_r_q) begin
            bar_l_q <= bar_of(peak_l);
            bar_r_q <= bar_of(peak_r);
        end
    end

    assign bus.bar_l = bar_l_q;
    assign bus.bar_r = bar_r_q;
`else
    assign bus.bar_l = '0;
    assign bus.bar_r = '0;
`endif

    assign bus.peak_l = peak_l;
    assign bus.peak_r = peak_r;
    assign bus.clip_l = clip_l;
    assign bus.clip_r = clip_r;
    assign bus.valid  = valid_q;

endmodule

// File: tb/tb_i2s_peak_meter.sv
// Randomised and directed bench for i2s_peak_meter against an integer model of
// the peak/hold/decay/clip rules, with per-close latency checks.
module tb_i2s_peak_meter;

    logic clk = 1'b0;
    logic rst;

    i2s_peak_meter_if bus ();

    i2s_peak_meter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef I2S_PEAK_METER_BAR_EN
    localparam logic [7:0] BAR_0300 = 8'h03;
`else
    localparam logic [7:0] BAR_0300 = 8'h00;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         vcnt     = 0;
    int         exp_vcnt = 0;
    int         m_peak[2];
    int         m_hold[2];
    bit         m_clip[2];
    logic [7:0] m_bar[2];
    bit         pending, fresh, have_prev, prev_c, next_c;
    logic [31:0] prev_w;
    int         prev_n;

    always @(negedge clk) if (bus.valid === 1'b1) vcnt++;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bar_model(input int p);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = (p >= (1 << (8 + k)));
        return b;
    endfunction

    // A slot of n bits taken closes for channel c; only exact 32-bit slots count.
    task automatic model_close(input bit c, input logic [31:0] w, input int n, output bit ev);
        int mag, d;
        logic signed [15:0] s;
        ev = 1'b0;
        if (n == 32) begin
            s   = w[31:16];
            mag = s;
            if (mag < 0) mag = -mag;
            if (mag > 32767) mag = 32767;
            if (mag == 32767) m_clip[c] = 1'b1;
            if (mag > m_peak[c]) begin
                m_peak[c] = mag;
                m_hold[c] = 4;
            end else if (m_hold[c] > 0) begin
                m_hold[c] = m_hold[c] - 1;
            end else begin
                d = m_peak[c] / 8;
                if (d == 0 && m_peak[c] > 0) d = 1;
                m_peak[c] = m_peak[c] - d;
            end
            if (c) begin
                ev = 1'b1;
                exp_vcnt++;
`ifdef I2S_PEAK_METER_BAR_EN
                m_bar[0] = bar_model(m_peak[0]);
                m_bar[1] = bar_model(m_peak[1]);
`endif
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_peak[i] = 0;
            m_hold[i] = 0;
            m_clip[i] = 1'b0;
            m_bar[i]  = 8'h00;
        end
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, "_peak_l"}, bus.peak_l, 0);
        chk_eq({tag, "_peak_r"}, bus.peak_r, 0);
        chk_eq({tag, "_clip_l"}, bus.clip_l, 0);
        chk_eq({tag, "_clip_r"}, bus.clip_r, 0);
        chk_eq({tag, "_valid"},  bus.valid,  0);
        chk_eq({tag, "_bar_l"},  bus.bar_l,  0);
        chk_eq({tag, "_bar_r"},  bus.bar_r,  0);
    endtask

    // One bclk period: 2 clk low, 3 clk high; on a closing bit the high phase
    // is used to check the E0/E1/E2 timing of the update.
    task automatic send_bit(input bit lr, input bit d, input bit closing, input bit ev);
        bus.lrclk = lr;
        bus.sd    = d;
        bus.bclk  = 1'b0;
        repeat (2) @(negedge clk);
        bus.bclk = 1'b1;
        @(negedge clk);
        if (closing) chk_eq("valid_e0", bus.valid, 0);
        @(negedge clk);
        if (closing) begin
            chk_eq("valid_e1", bus.valid, 0);
            chk_eq("peak_l", bus.peak_l, m_peak[0]);
            chk_eq("peak_r", bus.peak_r, m_peak[1]);
            chk_eq("clip_l", bus.clip_l, m_clip[0]);
            chk_eq("clip_r", bus.clip_r, m_clip[1]);
        end
        @(negedge clk);
        if (closing) begin
            chk_eq("valid_e2", bus.valid, ev);
            chk_eq("bar_l", bus.bar_l, m_bar[0]);
            chk_eq("bar_r", bus.bar_r, m_bar[1]);
        end
    endtask

    task automatic mid_reset();
        bus.bclk = 1'b0;
        rst      = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        fresh = 1'b1;
    endtask

    // Slot of n bits on channel c: the first rise carries the previous slot's LSB.
    task automatic send_slot(input bit c, input logic [31:0] w, input int n, input int rst_at);
        bit ev;
        ev = 1'b0;
        if (have_prev) model_close(prev_c, prev_w, prev_n, ev);
        send_bit(c, pending, have_prev, ev);
        for (int i = 1; i < n; i++) begin
            send_bit(c, (i < 32) ? w[32 - i] : 1'b1, 1'b0, 1'b0);
            if (i == rst_at) mid_reset();
        end
        pending   = (n <= 32) ? w[32 - n] : 1'b1;
        prev_c    = c;
        prev_w    = w;
        prev_n    = fresh ? 0 : n;
        fresh     = 1'b0;
        have_prev = 1'b1;
        next_c    = ~c;
    endtask

    task automatic pulse_clr();
        bus.clip_clr = 1'b1;
        @(negedge clk);
        bus.clip_clr = 1'b0;
        m_clip[0] = 1'b0;
        m_clip[1] = 1'b0;
        #1;
        chk_eq("clr_clip_l", bus.clip_l, 0);
        chk_eq("clr_clip_r", bus.clip_r, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          n, held;
        rst          = 1'b0;
        bus.bclk     = 1'b0;
        bus.lrclk    = 1'b0;
        bus.sd       = 1'b0;
        bus.clip_clr = 1'b0;
        model_reset();
        fresh     = 1'b1;
        have_prev = 1'b0;
        pending   = 1'b0;
        next_c    = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        send_slot(0, 32'h0, 32, 0);
        send_slot(1, 32'h0, 32, 0);
        send_slot(0, 32'h4000_0000, 32, 0);
        send_slot(1, 32'hC000_0000, 32, 0);

        // Hold then decay of a 0x4000 peak down to zero.
        for (int f = 0; f < 90; f++) begin
            send_slot(0, 32'h0, 32, 0);
            if (f == 0) begin
                chk_eq("first_peak_l", bus.peak_l, 32'h4000);
                chk_eq("first_peak_r", bus.peak_r, 32'h4000);
                chk_eq("first_vcnt", vcnt, exp_vcnt);
            end
            send_slot(1, 32'h0, 32, 0);
            if (f == 3) chk_eq("hold_end", bus.peak_l, 32'h4000);
            if (f == 4) chk_eq("decay_1", bus.peak_l, 32'h3800);
            if (f == 5) chk_eq("decay_2", bus.peak_l, 32'h3100);
        end
        send_slot(0, 32'h0, 32, 0);
        chk_eq("decayed_l", bus.peak_l, 0);
        chk_eq("decayed_r", bus.peak_r, 0);

        // Bar thresholds for a 0x0300 left peak.
        send_slot(1, 32'h0, 32, 0);
        send_slot(0, 32'h0300_0000, 32, 0);
        send_slot(1, 32'h0, 32, 0);
        send_slot(0, 32'h0, 32, 0);
        chk_eq("bar_0300_peak", bus.peak_l, 32'h0300);
        chk_eq("bar_0300", bus.bar_l, BAR_0300);

        // Negative full scale saturates and clips; positive full scale clips too.
        send_slot(1, 32'h0, 32, 0);
        send_slot(0, 32'h8000_1234, 32, 0);
        send_slot(1, 32'h7FFF_0000, 32, 0);
        send_slot(0, 32'h0, 32, 0);
        chk_eq("sat_peak_l", bus.peak_l, 32'h7FFF);
        chk_eq("sat_clip_l", bus.clip_l, 1);
        for (int f = 0; f < 3; f++) begin
            send_slot(1, 32'h0, 32, 0);
            send_slot(0, 32'h0, 32, 0);
        end
        chk_eq("sticky_clip_l", bus.clip_l, 1);
        pulse_clr();

        // Reset in the middle of a right slot; valid must stay quiet until a full right slot.
        held = exp_vcnt;
        send_slot(1, 32'h5000_0000, 32, 12);
        send_slot(0, 32'h2000_0000, 32, 0);
        chk_eq("post_rst_vcnt", vcnt, held);
        send_slot(1, 32'h3000_0000, 32, 0);
        send_slot(0, 32'h0, 32, 0);
        chk_eq("post_rst_peak_r", bus.peak_r, 32'h3000);
        chk_eq("post_rst_vcnt2", vcnt, exp_vcnt);

        // Left slot cut short after 20 bits is ignored.
        send_slot(1, 32'h0, 32, 0);
        send_slot(0, 32'h6000_0000, 20, 0);
        held = m_peak[0];
        send_slot(1, 32'h0, 32, 0);
        chk_eq("trunc_peak_l", bus.peak_l, held);
        send_slot(0, 32'h7000_0000, 32, 0);
        send_slot(1, 32'h0, 32, 0);
        chk_eq("trunc_next_l", bus.peak_l, 32'h7000);

        // Random words, occasional odd slot lengths and clip clears.
        for (int r = 0; r < 48; r++) begin
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w = {16'h8000, w[15:0]};
            if ($urandom_range(0, 3) == 0) w = w >> $urandom_range(4, 14);
            n = 32;
            if ($urandom_range(0, 5) == 0) n = $urandom_range(8, 36);
            send_slot(next_c, w, n, 0);
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end
        send_slot(next_c, 32'h0, 32, 0);
        chk_eq("final_vcnt", vcnt, exp_vcnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_peak_meter.md
Name: i2s_peak_meter

Overview:
- Downstream consumer of the bit-serial I2S-framed audio streams: the sum, shift, mixer and audio-out outputs.
- Deserialises one MSB-first stereo stream and produces per-channel absolute peak levels with hold and exponential decay, plus sticky clip flags.
- Feeds LED/7-segment level display logic in lab_top.
- bclk/lrclk are data signals sampled in the clk domain, not clocks.

Parameters:
- W_SLOT, 32: bits per channel slot on the serial line.
- W_OUT, 16: width of the magnitude/peak; the top W_OUT bits of each slot are used.
- HOLD_FRAMES, 4: frames a new peak is held before decay starts.
- DECAY_SHIFT, 3: per-frame decay is peak >> DECAY_SHIFT.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- bclk  in  1  bit clock level, sampled by clk.
- lrclk  in  1  word select (0 = left, 1 = right), sampled at bclk rise.
- sd  in  1  serial data, sampled at bclk rise.
- clip_clr  in  1  synchronous clear of both clip flags.
- peak_l  out  W_OUT  left peak magnitude.
- peak_r  out  W_OUT  right peak magnitude.
- clip_l  out  1  sticky left full-scale flag.
- clip_r  out  1  sticky right full-scale flag.
- valid  out  1  one-clk pulse after a frame update.
- bar_l  out  8  left thermometer bar (optional feature).
- bar_r  out  8  right thermometer bar (optional feature).

Behaviour:
- Reset (rst=0, async): every output 0. Shift register, bit counter, hold counters cleared. lrclk_prev is marked unknown, so the first slot after reset is discarded.
- bclk rise: bclk & ~bclk_q, registered in clk. All serial actions happen only on clk cycles where this is 1; with no rise nothing changes.
- Framing is standard I2S, offset by one bit. On a rise where the sampled lrclk differs from lrclk_prev:
  - sd is shifted in as the last bit of the previous slot.
  - The slot closes for channel lrclk_prev.
  - bit_cnt <= 0.
- Otherwise sd is shifted in while bit_cnt < W_SLOT, and bits beyond W_SLOT are ignored.
- A slot is complete only if exactly W_SLOT bits were taken including the closing bit. Incomplete slots are discarded: no peak update, no decay step, no valid.
- Sample = shreg[W_SLOT-1 -: W_OUT], two's complement.
- Magnitude = sign ? -sample : sample. -2^(W_OUT-1) saturates to 2^(W_OUT-1)-1 and sets clip.
- Clip: magnitude == 2^(W_OUT-1)-1 sets the channel's clip flag. The flag stays set until clip_clr=1. If clip_clr and a clipping slot close occur in the same cycle, set wins.
- Per-channel update, one clk after the slot close, in priority order:
  - mag > peak: peak <= mag, hold <= HOLD_FRAMES.
  - else hold > 0: hold <= hold-1.
  - else: peak <= peak - max(peak >> DECAY_SHIFT, (peak != 0)). Peak always reaches 0 and never underflows.
- valid pulses for one clk in the cycle after peak_r updates from a complete right slot.
- Latency: slot-closing bclk rise to peak register update is 1 clk; valid follows 1 clk later.
- Reset mid-slot clears everything; the resumed partial slot is discarded.

Optional Feature:
- Macro: I2S_PEAK_METER_BAR_EN.
- When defined: bar_x[k] = 1 when peak_x >= 2^(W_OUT-8+k), k = 0..7. The bar is registered and updates with valid.
- When undefined: bar_l and bar_r are tied to 0 and no comparator logic is built.

Decomposition:
- Package i2s_meter_pkg holds:
  - localparam defaults for W_OUT, HOLD_FRAMES and DECAY_SHIFT.
  - typedef logic [W_OUT-1:0] level_t.
  - Function sat_abs: magnitude with saturation and clip output.
- Sub-module i2s_meter_chan holds the hold counter, decay and clip flag for one channel. It is instantiated twice.
- The framing and deserialiser live in the top module.

Test Plan:
- rst=0 asserted mid-slot, bclk running -> all outputs 0 immediately. After release the first partial slot is discarded and valid stays 0 until the first complete right slot.
- Left slot 0x4000_0000, right slot 0xC000_0000 -> peak_l=0x4000, peak_r=0x4000, clip 0. Exactly one valid pulse, 2 clk after the closing bclk rise of the right slot.
- Left slot 0x8000_1234 -> peak_l=0x7FFF, clip_l=1. clip_l stays 1 over silent frames until clip_clr pulses, then 0.
- After peak 0x4000, zero-valued slots follow -> 0x4000 held for 4 frames, then 0x3800, 0x3100, ... down to 0 with no wrap. Peak 1 decays to 0 in one step.
- lrclk toggles after 20 bits of a left slot -> slot discarded, peak_l and hold unchanged. The next full frame updates normally.
- With I2S_PEAK_METER_BAR_EN and peak_l=0x0300 -> bar_l=8'b0000_0011. Without the macro -> bar_l=0.
